alu_issue_stage: RTL and testbench

Decode/operand-issue stage directly upstream of the ALU. It accepts 9-bit instruction words over a valid/ready handshake and decodes the opcode into the 4-bit ALU operation code. It reads operands from an internal 8-entry x 8-bit register file and presents one registered operation per cycle to the ALU's ALUOp/A/B inputs. ALU results return through a writeback port that updates the register file, the carry flag and a per-register pending scoreboard.

---
 rtl/alu_issue_pkg.sv | 33 +++
 rtl/alu_issue_if.sv | 39 +++
 rtl/alu_regfile.sv | 57 +++++
 rtl/alu_issue_stage.sv | 128 ++++++++++++
 tb/tb_alu_issue_stage.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: ALU operation encoding,
// instruction field positions and reserved-opcode detection.
package alu_issue_pkg;

    typedef enum logic [3:0] {
        OP_PASS_A       = 4'd0,
        OP_SHIFT_LEFT   = 4'd1,
        OP_SHIFT_RIGHT  = 4'd2,
        OP_KEEP_SMALLER = 4'd3,
        OP_SHIFT_ON     = 4'd4,
        OP_ADD          = 4'd5,
        OP_A_IS_ZERO    = 4'd6,
        OP_PASS_B       = 4'd7,
        OP_INC_A        = 4'd8,
        OP_DEC_A        = 4'd9,
        OP_CLEAR        = 4'd10,
        OP_SUB          = 4'd11
    } op_mne_e;

    localparam int INSTR_W = 9;
    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 5;
    localparam int RS_MSB  = 4;
    localparam int RS_LSB  = 2;
    localparam int RT_MSB  = 1;
    localparam int RT_LSB  = 0;

    // Opcodes above the last ALU operation have no ALU meaning.
    function automatic logic is_reserved(input logic [3:0] opc);
        return opc > OP_SUB;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the issue stage's instruction, execute and writeback channels.
// master: the surrounding pipeline; slave: the issue stage.
interface alu_issue_if
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               ex_valid;
    logic               ex_ready;
    logic [3:0]         ex_op;
    logic [WIDTH-1:0]   ex_a;
    logic [WIDTH-1:0]   ex_b;
    logic [2:0]         ex_dest;
    logic               ex_wr;
    logic               wb_en;
    logic [2:0]         wb_addr;
    logic [WIDTH-1:0]   wb_data;
    logic               wb_carry_en;
    logic               wb_carry;
    logic               carry_flag;
    logic               illegal;

    modport master (
        output in_valid, in_instr, ex_ready,
        output wb_en, wb_addr, wb_data, wb_carry_en, wb_carry,
        input  in_ready, ex_valid, ex_op, ex_a, ex_b, ex_dest, ex_wr,
        input  carry_flag, illegal
    );

    modport slave (
        input  in_valid, in_instr, ex_ready,
        input  wb_en, wb_addr, wb_data, wb_carry_en, wb_carry,
        output in_ready, ex_valid, ex_op, ex_a, ex_b, ex_dest, ex_wr,
        output carry_flag, illegal
    );
endinterface

// File: rtl/alu_regfile.sv
// Register file with two combinational read ports, one synchronous write
// port, and a pending bit per register tracking in-flight results.
module alu_regfile #(
    parameter int  NREGS = 8,
    parameter int  WIDTH = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_pend_a,
    output logic             rd_pend_b,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr
);
    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] mem_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];
    assign rd_pend_a = pend_q[rd_addr_a];
    assign rd_pend_b = pend_q[rd_addr_b];

    // Writeback updates storage and clears pending; a new issue to the same register wins.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_en) begin
            mem_d[wr_addr]  = wr_data;
            pend_d[wr_addr] = 1'b0;
        end
        if (set_en) begin
            pend_d[set_addr] = 1'b1;
        end
    end

    // Storage and scoreboard registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/alu_issue_stage.sv
// Decode/operand-issue stage in front of the ALU: decodes the opcode, reads
// operands, stalls on RAW hazards and registers one operation per cycle.
// Optional build macro ALU_ISSUE_FORWARD_EN lets a pending operand take the
// same-cycle writeback value instead of stalling.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        reset,
    alu_issue_if.slave bus
);
    logic [3:0]       opc;
    logic [2:0]       rs;
    logic [2:0]       rt_addr;
    logic [WIDTH-1:0] rd_a, rd_b, opnd_a, opnd_b;
    logic             pend_a, pend_b, fwd_a, fwd_b;
    logic             hazard, accept, legal, writes;

    logic             ex_valid_q, ex_valid_d;
    op_mne_e          ex_op_q, ex_op_d;
    logic [WIDTH-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
    logic [2:0]       ex_dest_q, ex_dest_d;
    logic             ex_wr_q, ex_wr_d;
    logic             illegal_q, illegal_d;
    logic             carry_q, carry_d;
    logic             init_q, init_d;

    assign opc     = bus.in_instr[OPC_MSB:OPC_LSB];
    assign rs      = bus.in_instr[RS_MSB:RS_LSB];
    assign rt_addr = {1'b0, bus.in_instr[RT_MSB:RT_LSB]};
    assign legal   = !is_reserved(opc);
    assign writes  = legal && (opc != OP_A_IS_ZERO);

    alu_regfile #(.NREGS(NREGS), .WIDTH(WIDTH)) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (rs),
        .rd_addr_b (rt_addr),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b),
        .rd_pend_a (pend_a),
        .rd_pend_b (pend_b),
        .wr_en     (bus.wb_en),
        .wr_addr   (bus.wb_addr),
        .wr_data   (bus.wb_data),
        .set_en    (accept && writes),
        .set_addr  (rs)
    );

`ifdef ALU_ISSUE_FORWARD_EN
    assign fwd_a = pend_a && bus.wb_en && (bus.wb_addr == rs);
    assign fwd_b = pend_b && bus.wb_en && (bus.wb_addr == rt_addr);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    assign opnd_a = fwd_a ? bus.wb_data : rd_a;
    assign opnd_b = fwd_b ? bus.wb_data : rd_b;
    assign hazard = (pend_a && !fwd_a) || (pend_b && !fwd_b);

    // init_q keeps the stage closed for the first cycle after reset.
    assign bus.in_ready = !reset && init_q && (!ex_valid_q || bus.ex_ready) && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    // Next-state of the execute register: load on accept, drain on ex_ready, else hold.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_dest_d  = ex_dest_q;
        ex_wr_d    = ex_wr_q;
        illegal_d  = 1'b0;
        init_d     = 1'b1;
        carry_d    = bus.wb_carry_en ? bus.wb_carry : carry_q;
        if (accept) begin
            ex_valid_d = legal;
            illegal_d  = !legal;
            if (legal) begin
                ex_op_d   = op_mne_e'(opc);
                ex_a_d    = opnd_a;
                ex_b_d    = opnd_b;
                ex_dest_d = rs;
                ex_wr_d   = writes;
            end
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // Pipeline, flag and startup registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= OP_PASS_A;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_dest_q  <= '0;
            ex_wr_q    <= 1'b0;
            illegal_q  <= 1'b0;
            carry_q    <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_dest_q  <= ex_dest_d;
            ex_wr_q    <= ex_wr_d;
            illegal_q  <= illegal_d;
            carry_q    <= carry_d;
            init_q     <= init_d;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_op      = ex_op_q;
    assign bus.ex_a       = ex_a_q;
    assign bus.ex_b       = ex_b_q;
    assign bus.ex_dest    = ex_dest_q;
    assign bus.ex_wr      = ex_wr_q;
    assign bus.illegal    = illegal_q;
    assign bus.carry_flag = carry_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    alu_issue_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_regs [8];
    logic [7:0] m_pend;
    logic       m_carry, m_ill, m_fresh;
    logic       m_known = 1'b0;
    logic       m_exv, m_exwr;
    logic [3:0] m_exop;
    logic [7:0] m_exa, m_exb;
    logic [2:0] m_exdest;

    function automatic logic blocked(input logic [2:0] r);
        logic b;
        b = m_pend[r];
`ifdef ALU_ISSUE_FORWARD_EN
        if (bus.wb_en && bus.wb_addr == r) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic [7:0] opnd(input logic [2:0] r);
`ifdef ALU_ISSUE_FORWARD_EN
        if (m_pend[r] && bus.wb_en && bus.wb_addr == r) return bus.wb_data;
`endif
        return m_regs[r];
    endfunction

    // Inputs change just after posedge, so at negedge they are what the next edge samples.
    always @(negedge clk) begin : cmp
        logic [3:0] opc;
        logic [2:0] rs, rt;
        logic       rdy, acc;
        opc = bus.in_instr[8:5];
        rs  = bus.in_instr[4:2];
        rt  = {1'b0, bus.in_instr[1:0]};
        rdy = !reset && !m_fresh && (!m_exv || bus.ex_ready) && !blocked(rs) && !blocked(rt);
        if (m_known) begin
            chk("in_ready", bus.in_ready, rdy);
            chk("ex_valid", bus.ex_valid, m_exv);
            chk("illegal", bus.illegal, m_ill);
            chk("carry_flag", bus.carry_flag, m_carry);
            if (m_exv || m_fresh) begin
                chk("ex_op", bus.ex_op, m_exop);
                chk("ex_a", bus.ex_a, m_exa);
                chk("ex_b", bus.ex_b, m_exb);
                chk("ex_dest", bus.ex_dest, m_exdest);
                chk("ex_wr", bus.ex_wr, m_exwr);
            end
        end
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            m_pend = 8'h00; m_carry = 1'b0; m_ill = 1'b0;
            m_exv = 1'b0; m_exop = 4'd0; m_exa = 8'h00; m_exb = 8'h00;
            m_exdest = 3'd0; m_exwr = 1'b0;
            m_fresh = 1'b1; m_known = 1'b1;
        end else if (m_known) begin
            acc   = bus.in_valid && rdy;
            m_ill = acc && (opc >= 4'd12);
            if (acc && opc < 4'd12) begin
                m_exv = 1'b1; m_exop = opc; m_exa = opnd(rs); m_exb = opnd(rt);
                m_exdest = rs; m_exwr = (opc != 4'd6);
            end else if (acc || bus.ex_ready) begin
                m_exv = 1'b0;
            end
            if (bus.wb_en) m_pend[bus.wb_addr] = 1'b0;
            if (acc && opc < 4'd12 && opc != 4'd6) m_pend[rs] = 1'b1;
            if (bus.wb_en) m_regs[bus.wb_addr] = bus.wb_data;
            if (bus.wb_carry_en) m_carry = bus.wb_carry;
            m_fresh = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.in_instr = 9'd0; bus.ex_ready = 1'b1;
        bus.wb_en = 1'b0; bus.wb_addr = 3'd0; bus.wb_data = 8'h00;
        bus.wb_carry_en = 1'b0; bus.wb_carry = 1'b0;
    endtask

    task automatic send(input logic [8:0] instr);
        logic got;
        got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = bus.in_ready;
            tick();
        end
        chk("send_accepted", got, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wb(input logic [2:0] addr, input logic [7:0] data);
        bus.wb_en = 1'b1; bus.wb_addr = addr; bus.wb_data = data;
        tick();
        bus.wb_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_ex_valid", bus.ex_valid, 1'b0);
        chk("rst_carry", bus.carry_flag, 1'b0);
        chk("rst_illegal", bus.illegal, 1'b0);

        // ADD R1,R2 on a freshly reset file
        send({4'd5, 3'd1, 2'd2});
        chk("add_valid", bus.ex_valid, 1'b1);
        chk("add_op", bus.ex_op, 4'd5);
        chk("add_a", bus.ex_a, 8'h00);
        chk("add_b", bus.ex_b, 8'h00);
        chk("add_dest", bus.ex_dest, 3'd1);
        chk("add_wr", bus.ex_wr, 1'b1);

        // SUB after writebacks
        wb(3'd1, 8'h12);
        wb(3'd2, 8'h34);
        send({4'd11, 3'd1, 2'd2});
        chk("sub_op", bus.ex_op, 4'd11);
        chk("sub_a", bus.ex_a, 8'h12);
        chk("sub_b", bus.ex_b, 8'h34);
        wb(3'd1, 8'h46);

        // RAW hazard: INC_A R3 then ADD rs=3
        send({4'd8, 3'd3, 2'd0});
        bus.in_valid = 1'b1;
        bus.in_instr = {4'd5, 3'd3, 2'd0};
        repeat (3) begin
            @(negedge clk);
            chk("raw_stall", bus.in_ready, 1'b0);
            tick();
        end
        bus.wb_en = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 8'h55;
        @(negedge clk);
`ifdef ALU_ISSUE_FORWARD_EN
        chk("raw_wb_cycle_ready", bus.in_ready, 1'b1);
        tick();
        bus.wb_en = 1'b0;
`else
        chk("raw_wb_cycle_ready", bus.in_ready, 1'b0);
        tick();
        bus.wb_en = 1'b0;
        @(negedge clk);
        chk("raw_after_wb_ready", bus.in_ready, 1'b1);
        tick();
`endif
        bus.in_valid = 1'b0;
        chk("raw_issue_valid", bus.ex_valid, 1'b1);
        chk("raw_issue_op", bus.ex_op, 4'd5);
        chk("raw_issue_a", bus.ex_a, 8'h55);
        wb(3'd3, 8'h60);

        // Backpressure: hold PASS_A R5,R1 for three cycles
        send({4'd0, 3'd5, 2'd1});
        bus.ex_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = {4'd7, 3'd6, 2'd2};
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", bus.in_ready, 1'b0);
            chk("hold_valid", bus.ex_valid, 1'b1);
            chk("hold_op", bus.ex_op, 4'd0);
            chk("hold_b", bus.ex_b, 8'h46);
            chk("hold_dest", bus.ex_dest, 3'd5);
            tick();
        end
        bus.ex_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("release_op", bus.ex_op, 4'd7);
        chk("release_dest", bus.ex_dest, 3'd6);
        chk("release_b", bus.ex_b, 8'h34);
        wb(3'd5, 8'h05);
        wb(3'd6, 8'h06);

        // Reserved opcode 13
        send({4'd13, 3'd6, 2'd1});
        chk("ill_pulse", bus.illegal, 1'b1);
        chk("ill_no_valid", bus.ex_valid, 1'b0);
        bus.in_instr = {4'd0, 3'd6, 2'd0};
        #1;
        chk("ill_no_pending", bus.in_ready, 1'b1);
        tick();
        chk("ill_pulse_end", bus.illegal, 1'b0);

        // A_IS_ZERO on R4 and carry update
        send({4'd6, 3'd4, 2'd0});
        chk("aiz_op", bus.ex_op, 4'd6);
        chk("aiz_wr", bus.ex_wr, 1'b0);
        bus.in_instr = {4'd5, 3'd4, 2'd0};
        #1;
        chk("aiz_no_stall", bus.in_ready, 1'b1);
        bus.wb_carry_en = 1'b1; bus.wb_carry = 1'b1;
        tick();
        bus.wb_carry_en = 1'b0;
        chk("carry_set", bus.carry_flag, 1'b1);

        // Randomized traffic, including occasional mid-operation reset
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.in_instr    = 9'($urandom);
            bus.ex_ready    = ($urandom_range(0, 3) != 0);
            bus.wb_en       = ($urandom_range(0, 2) == 0);
            bus.wb_addr     = 3'($urandom);
            bus.wb_data     = 8'($urandom);
            bus.wb_carry_en = ($urandom_range(0, 3) == 0);
            bus.wb_carry    = 1'($urandom);
            reset           = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
